// File: rtl/serial_pattern_gen_pkg.sv
// rtl/serial_pattern_gen_pkg.sv - shared types and default widths for the serial pattern generator
package serial_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_PAT_W = 16;
    localparam int DEF_LEN_W = 5;
    localparam int DEF_REP_W = 4;
    localparam int DEF_GAP_W = 4;

endpackage

// File: rtl/pg_down_counter.sv
// rtl/pg_down_counter.sv - loadable down-counter with zero flag; load wins over decrement
module pg_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Saturates at zero so a stray decrement can never wrap the count
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - MSB-first serial pattern transmitter with repeat count and idle gap
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             abort,
    output logic             sout,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_q;
    logic sout_q, sout_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic capture;

    logic             idx_load, idx_dec, idx_zero;
    logic [LEN_W-1:0] idx_val, idx_cnt;
    logic             rep_load, rep_dec, rep_zero;
    logic [REP_W-1:0] rep_cnt_w;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_val, gap_cnt_w;
    logic             unused_cnt;

    function automatic logic pick(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    wire len_ok = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));

    pg_down_counter #(.W(LEN_W)) u_idx (
        .clk(clk), .rst_n(rst_n), .load_i(idx_load), .load_val_i(idx_val),
        .dec_i(idx_dec), .cnt_o(idx_cnt), .zero_o(idx_zero)
    );

    pg_down_counter #(.W(REP_W)) u_rep (
        .clk(clk), .rst_n(rst_n), .load_i(rep_load), .load_val_i(rep_cnt),
        .dec_i(rep_dec), .cnt_o(rep_cnt_w), .zero_o(rep_zero)
    );

    pg_down_counter #(.W(GAP_W)) u_gap (
        .clk(clk), .rst_n(rst_n), .load_i(gap_load), .load_val_i(gap_val),
        .dec_i(gap_dec), .cnt_o(gap_cnt_w), .zero_o(gap_zero)
    );

    assign unused_cnt = ^{rep_cnt_w, gap_cnt_w};

    // Outputs are computed one cycle ahead so they leave the flops aligned with the state
    always_comb begin
        state_d  = state_q;
        sout_d   = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        capture  = 1'b0;
        idx_load = 1'b0;
        idx_val  = len_q - 1'b1;
        idx_dec  = 1'b0;
        rep_load = 1'b0;
        rep_dec  = 1'b0;
        gap_load = 1'b0;
        gap_val  = gap_q - 1'b1;
        gap_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    state_d  = SEND;
                    capture  = 1'b1;
                    idx_load = 1'b1;
                    idx_val  = pat_len - 1'b1;
                    rep_load = 1'b1;
                    sout_d   = pick(pattern, pat_len - 1'b1);
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!idx_zero) begin
                    idx_dec = 1'b1;
                    sout_d  = pick(pat_q, idx_cnt - 1'b1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (!rep_zero && (gap_q != '0)) begin
                    state_d  = GAP;
                    rep_dec  = 1'b1;
                    gap_load = 1'b1;
                    busy_d   = 1'b1;
                end else if (!rep_zero) begin
                    rep_dec  = 1'b1;
                    idx_load = 1'b1;
                    sout_d   = pick(pat_q, len_q - 1'b1);
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_zero) begin
                    state_d  = SEND;
                    idx_load = 1'b1;
                    sout_d   = pick(pat_q, len_q - 1'b1);
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (capture) begin
                pat_q <= pattern;
                len_q <= pat_len;
                gap_q <= gap_len;
            end
        end
    end

    assign sout  = sout_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - scoreboard bench for serial_pattern_gen
module tb_serial_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  pat_len;
    logic [3:0]  rep_cnt;
    logic [3:0]  gap_len;
    logic        abort;
    logic        sout, valid, busy, done;

    int n_checks = 0;
    int n_pass   = 0;
    string cur_tag = "reset";
    logic [3:0] exp_q[$];

    serial_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .pat_len(pat_len), .rep_cnt(rep_cnt), .gap_len(gap_len), .abort(abort),
        .sout(sout), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Expected per-cycle {sout,valid,busy,done} from the capture edge onward
    task automatic push_xfer(input logic [15:0] p, input int len, input int rep, input int gap);
        for (int r = 0; r <= rep; r++) begin
            for (int i = len - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
            if (r < rep) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
    endtask

    task automatic drive(input logic [15:0] p, input int len, input int rep, input int gap);
        start   = 1'b1;
        pattern = p;
        pat_len = 5'(len);
        rep_cnt = 4'(rep);
        gap_len = 4'(gap);
    endtask

    // Start at the next edge; captured inputs are scrambled afterwards to show they are held
    task automatic start_xfer(input logic [15:0] p, input int len, input int rep, input int gap);
        @(posedge clk); #1;
        drive(p, len, rep, gap);
        @(posedge clk); #1;
        start   = 1'b0;
        pattern = ~p;
        pat_len = 5'($urandom_range(1, 16));
        rep_cnt = 4'($urandom);
        gap_len = 4'($urandom);
        push_xfer(p, len, rep, gap);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({cur_tag, "_timeout"}, 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check(cur_tag, {sout, valid, busy, done}, e);
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; pattern = '0; pat_len = '0;
        rep_cnt = '0; gap_len = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset", {sout, valid, busy, done}, 4'b0000);
        rst_n = 1'b1;

        cur_tag = "single";
        start_xfer(16'h0007, 3, 0, 0);
        wait_drain();

        cur_tag = "rep_gap";
        start_xfer(16'h000A, 4, 1, 2);
        wait_drain();

        cur_tag = "rep_nogap";
        start_xfer(16'h0005, 3, 2, 0);
        wait_drain();

        cur_tag = "abort";
        @(posedge clk); #1;
        drive(16'h0007, 3, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0000);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        cur_tag = "after_abort";
        drive(16'h0005, 3, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        push_xfer(16'h0005, 3, 0, 0);
        wait_drain();

        cur_tag = "len_zero";
        @(posedge clk); #1;
        drive(16'hFFFF, 0, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        push_idle(3);
        wait_drain();

        cur_tag = "len_17";
        @(posedge clk); #1;
        drive(16'hFFFF, 17, 0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        push_idle(3);
        wait_drain();

        cur_tag = "start_in_done";
        start_xfer(16'h0007, 3, 0, 0);
        repeat (3) @(posedge clk);
        #1 drive(16'h0007, 3, 0, 0);
        push_idle(2);
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain();

        cur_tag = "async_reset";
        @(posedge clk); #1;
        drive(16'h000A, 4, 1, 2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 check("in_gap", {valid, busy}, 2'b01);
        rst_n = 1'b0;
        #1 check("async_reset", {sout, valid, busy, done}, 4'b0000);
        #3 rst_n = 1'b1;
        cur_tag = "after_reset";
        start_xfer(16'h0007, 3, 0, 0);
        wait_drain();

        for (int k = 0; k < 6; k++) begin
            logic [15:0] p;
            int l, r, g;
            p = 16'($urandom);
            l = $urandom_range(1, 16);
            r = $urandom_range(0, 2);
            g = $urandom_range(0, 3);
            cur_tag = "random";
            start_xfer(p, l, r, g);
            wait_drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
